mem_bus_master: RTL and testbench
=================================

# mem_bus_master

CPU-side initiator for the shared single-port 16-bit memory bus (`read_m`, `write_m`, `address`, bidirectional `data`). It arbitrates between an instruction-fetch port and a data load/store port, with fixed priority to data. It sequences each access into bus cycles and owns the tristate driver on `data`. It sits between the multi-cycle CPU datapath and the memory model.

## Interface
- `WORD_SIZE`, 16: width of address and data.
- `READ_LATENCY`, 2: cycles `read_m` is held before read data is captured; legal range 1–7.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `i_req_valid` in 1: fetch request.
- `i_req_ready` out 1: fetch accepted when valid && ready.
- `i_req_addr` in WORD_SIZE: fetch address.
- `i_resp_valid` out 1: one-cycle pulse; `i_resp_data` is valid.
- `i_resp_data` out WORD_SIZE: fetched word, held until the next capture.
- `d_req_valid` in 1: data request.
- `d_req_ready` out 1: data request accepted when valid && ready.
- `d_req_write` in 1: 1 = store, 0 = load.
- `d_req_addr` in WORD_SIZE: data address.
- `d_req_wdata` in WORD_SIZE: store data.
- `d_resp_valid` out 1: one-cycle pulse; load data valid, or store complete.
- `d_resp_data` out WORD_SIZE: loaded word, held until the next capture.
- `read_m` out 1: memory read strobe.
- `write_m` out 1: memory write strobe.
- `address` out WORD_SIZE: bus address.
- `data` inout WORD_SIZE: driven only while `write_m`=1, otherwise high-Z.

## Operation
- FSM states are IDLE, RD, WR and RESP.
- **IDLE:**
  - Both ready outputs are high only in IDLE, gated by arbitration.
  - If `d_req_valid`, the d-port is accepted and `i_req_ready` is 0 that cycle.
  - Otherwise, if `i_req_valid`, the i-port is accepted.
  - On acceptance, the address, write flag, wdata and owner (I/D) are latched.
  - A load or fetch goes to RD; a store goes to WR.
- **RD:**
  - `read_m`=1, `address` = latched address, `data` released.
  - A latency counter loads READ_LATENCY-1 on entry and counts down.
  - On the cycle the counter reaches 0, `data` is captured into the owner's resp_data register, then the FSM goes to RESP.
- **WR:**
  - Lasts exactly one cycle: `write_m`=1, `address` = latched address, `data` = latched wdata.
  - Then goes to RESP.
- **RESP:**
  - The owner's resp_valid is 1 for this single cycle.
  - Bus strobes are 0, `data` is high-Z.
  - Then goes to IDLE.
- Invariants:
  - `read_m` and `write_m` are never both 1.
  - `data` is never driven while `read_m`=1.
  - `address` holds the latched value in RD/WR and is 0 otherwise.
- Fetch requests carry no write path; the i-port is read-only by construction.
- Starvation: a continuously valid d-port starves the i-port. This is accepted, because the CPU issues one access at a time.

## Timing
- Acceptance in cycle T.
- Load/fetch:
  - `read_m` high during T+1 … T+READ_LATENCY.
  - Data captured at the end of T+READ_LATENCY.
  - resp_valid in T+READ_LATENCY+1.
  - Ready again in T+READ_LATENCY+2.
  - Default total: accept-to-resp = 3 cycles.
- Store:
  - `write_m`/`data` driven in T+1.
  - `d_resp_valid` in T+2.
  - Ready again in T+3.
- Back-to-back read→write: RESP separates the two accesses, so at least 1 cycle passes with `data` undriven by both sides.
- Reset values: all ready outputs 0, both resp_valid 0, both resp_data 0, `read_m` 0, `write_m` 0, `address` 0, `data` high-Z, state IDLE, counter 0.
- Ready outputs are 1 from the first cycle after reset deasserts.
- Reset asserted mid-access:
  - Next cycle is IDLE with all strobes 0.
  - The in-flight access is dropped and produces no response.
  - resp_data keeps its reset value of 0.
- Simultaneous i/d valid in IDLE: d is accepted; i stays pending and is accepted in the next IDLE cycle.

## Configuration
- `MEM_BUS_MASTER_PERF_EN` defined:
  - Adds outputs `perf_reads`, `perf_writes` and `perf_stall` (16 bits each).
  - `perf_reads` and `perf_writes` count accepted loads/fetches and stores.
  - `perf_stall` counts cycles where any valid is 1 and the matching ready is 0.
  - All counters saturate at 16'hFFFF and clear on reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package `mem_bus_pkg`:
  - `WORD_SIZE` constant.
  - State enum `mbm_state_t` {IDLE, RD, WR, RESP}.
  - Owner enum {OWN_I, OWN_D}.
- Sub-module `mem_bus_arbiter`: combinational fixed-priority grant producing both ready outputs and the selected request fields.
- The top level holds the FSM, latency counter, tristate and response registers.

## Test plan
- Reset held 3 cycles, then released → all outputs at reset values during reset; both ready outputs 1 one cycle after release; `data` high-Z throughout.
- Fetch at 16'h0023, memory word 16'h6000, READ_LATENCY=2 → `read_m` high 2 cycles with `address`=16'h0023; `i_resp_valid` 3 cycles after accept; `i_resp_data`=16'h6000.
- Store 16'hBEEF to 16'h0050, then load 16'h0050 → `write_m` high 1 cycle with `data`=16'hBEEF; load returns 16'hBEEF on `d_resp_data`; no cycle has both strobes high.
- i and d valid in the same cycle (fetch 16'h0001, load 16'h0002) → d served first; i accepted after d's RESP; each response appears only on its own port.
- Reset pulsed during RD → `read_m` 0 the next cycle; no resp_valid for the dropped access; a new fetch after reset completes normally.
- With `MEM_BUS_MASTER_PERF_EN`: 3 loads, 2 stores, 1 contended cycle → `perf_reads`=3, `perf_writes`=2, `perf_stall`≥1.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the CPU-side memory bus master.
package mem_bus_pkg;

  localparam int WORD_SIZE = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } mbm_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } mbm_owner_t;

endpackage

// File: rtl/mem_bus_master_if.sv
// CPU request/response ports and memory bus strobes/address for mem_bus_master.
// The bidirectional data lines stay a plain port on the master so the
// tristate driver lives in exactly one module.
interface mem_bus_master_if;
  import mem_bus_pkg::*;

  logic                 i_req_valid;
  logic                 i_req_ready;
  logic [WORD_SIZE-1:0] i_req_addr;
  logic                 i_resp_valid;
  logic [WORD_SIZE-1:0] i_resp_data;

  logic                 d_req_valid;
  logic                 d_req_ready;
  logic                 d_req_write;
  logic [WORD_SIZE-1:0] d_req_addr;
  logic [WORD_SIZE-1:0] d_req_wdata;
  logic                 d_resp_valid;
  logic [WORD_SIZE-1:0] d_resp_data;

  logic                 read_m;
  logic                 write_m;
  logic [WORD_SIZE-1:0] address;

  modport master (
    input  i_req_valid, i_req_addr,
    input  d_req_valid, d_req_write, d_req_addr, d_req_wdata,
    output i_req_ready, i_resp_valid, i_resp_data,
    output d_req_ready, d_resp_valid, d_resp_data,
    output read_m, write_m, address
  );

  modport slave (
    output i_req_valid, i_req_addr,
    output d_req_valid, d_req_write, d_req_addr, d_req_wdata,
    input  i_req_ready, i_resp_valid, i_resp_data,
    input  d_req_ready, d_resp_valid, d_resp_data,
    input  read_m, write_m, address
  );

endinterface

// File: rtl/mem_bus_arbiter.sv
// Fixed-priority grant between the fetch port and the data port.
// Data always wins; the fetch port only sees ready when data is not asking.
module mem_bus_arbiter
  import mem_bus_pkg::*;
(
  input  logic                 idle,
  input  logic                 i_req_valid,
  input  logic [WORD_SIZE-1:0] i_req_addr,
  input  logic                 d_req_valid,
  input  logic                 d_req_write,
  input  logic [WORD_SIZE-1:0] d_req_addr,
  input  logic [WORD_SIZE-1:0] d_req_wdata,
  output logic                 i_req_ready,
  output logic                 d_req_ready,
  output logic                 accept,
  output mbm_owner_t           sel_owner,
  output logic [WORD_SIZE-1:0] sel_addr,
  output logic                 sel_write,
  output logic [WORD_SIZE-1:0] sel_wdata
);

  // grant and mux the winning request fields; fetch carries no write data
  always_comb begin
    d_req_ready = idle;
    i_req_ready = idle && !d_req_valid;
    sel_owner   = OWN_I;
    sel_addr    = i_req_addr;
    sel_write   = 1'b0;
    sel_wdata   = '0;
    if (d_req_valid) begin
      sel_owner = OWN_D;
      sel_addr  = d_req_addr;
      sel_write = d_req_write;
      sel_wdata = d_req_wdata;
    end
    accept = (d_req_valid && d_req_ready) || (i_req_valid && i_req_ready);
  end

endmodule

// File: rtl/mem_bus_master.sv
// CPU-side initiator for the shared single-port memory bus.
// Optional macro MEM_BUS_MASTER_PERF_EN adds saturating perf counters
// (perf_reads, perf_writes, perf_stall).
//
// state | meaning
// IDLE  | ready to accept; arbiter picks data over fetch
// RD    | read_m held, latency counter runs down, capture at 0
// WR    | single write cycle, data driven from latched wdata
// RESP  | one-cycle resp_valid on the owner's port, bus quiet
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int READ_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_bus_master_if.master     bus,
  inout  wire [WORD_SIZE-1:0]  data
`ifdef MEM_BUS_MASTER_PERF_EN
  ,
  output logic [15:0]          perf_reads,
  output logic [15:0]          perf_writes,
  output logic [15:0]          perf_stall
`endif
);

  localparam logic [2:0] LAT_INIT = 3'(READ_LATENCY - 1);

  mbm_state_t           state, state_nx;
  mbm_owner_t           owner;
  logic [WORD_SIZE-1:0] lat_addr;
  logic [WORD_SIZE-1:0] lat_wdata;
  logic                 lat_write;
  logic [2:0]           lat_cnt;
  logic [WORD_SIZE-1:0] i_resp_data_q;
  logic [WORD_SIZE-1:0] d_resp_data_q;

  logic                 idle;
  logic                 i_ready;
  logic                 d_ready;
  logic                 accept;
  mbm_owner_t           sel_owner;
  logic [WORD_SIZE-1:0] sel_addr;
  logic                 sel_write;
  logic [WORD_SIZE-1:0] sel_wdata;

  logic                 read_m;
  logic                 write_m;
  logic [WORD_SIZE-1:0] address;
  logic                 drive_en;
  logic                 i_resp_valid;
  logic                 d_resp_valid;

  // ready is held low while reset is asserted so nothing is accepted then
  assign idle = (state == IDLE) && !reset;

  mem_bus_arbiter u_arb (
    .idle        (idle),
    .i_req_valid (bus.i_req_valid),
    .i_req_addr  (bus.i_req_addr),
    .d_req_valid (bus.d_req_valid),
    .d_req_write (bus.d_req_write),
    .d_req_addr  (bus.d_req_addr),
    .d_req_wdata (bus.d_req_wdata),
    .i_req_ready (i_ready),
    .d_req_ready (d_ready),
    .accept      (accept),
    .sel_owner   (sel_owner),
    .sel_addr    (sel_addr),
    .sel_write   (sel_write),
    .sel_wdata   (sel_wdata)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = sel_write ? WR : RD;
      RD:      if (lat_cnt == 3'd0) state_nx = RESP;
      WR:      state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // bus strobes, address and response pulses decoded from state
  always_comb begin
    read_m       = 1'b0;
    write_m      = 1'b0;
    drive_en     = 1'b0;
    address      = '0;
    i_resp_valid = 1'b0;
    d_resp_valid = 1'b0;
    case (state)
      RD: begin
        read_m  = 1'b1;
        address = lat_addr;
      end
      WR: begin
        write_m  = lat_write;
        drive_en = lat_write;
        address  = lat_addr;
      end
      RESP: begin
        i_resp_valid = (owner == OWN_I);
        d_resp_valid = (owner == OWN_D);
      end
      default: ;
    endcase
  end

  // request latch, read latency down-counter and response capture
  always_ff @(posedge clk) begin
    if (reset) begin
      owner         <= OWN_I;
      lat_addr      <= '0;
      lat_wdata     <= '0;
      lat_write     <= 1'b0;
      lat_cnt       <= 3'd0;
      i_resp_data_q <= '0;
      d_resp_data_q <= '0;
    end else begin
      if (accept) begin
        owner     <= sel_owner;
        lat_addr  <= sel_addr;
        lat_wdata <= sel_wdata;
        lat_write <= sel_write;
        lat_cnt   <= LAT_INIT;
      end
      if (state == RD) begin
        if (lat_cnt == 3'd0) begin
          if (owner == OWN_D) d_resp_data_q <= data;
          else                i_resp_data_q <= data;
        end else begin
          lat_cnt <= lat_cnt - 3'd1;
        end
      end
    end
  end

  // only this master drives the data lines, and only during a write cycle
  assign data = drive_en ? lat_wdata : {WORD_SIZE{1'bz}};

  assign bus.i_req_ready  = i_ready;
  assign bus.d_req_ready  = d_ready;
  assign bus.i_resp_valid = i_resp_valid;
  assign bus.d_resp_valid = d_resp_valid;
  assign bus.i_resp_data  = i_resp_data_q;
  assign bus.d_resp_data  = d_resp_data_q;
  assign bus.read_m       = read_m;
  assign bus.write_m      = write_m;
  assign bus.address      = address;

`ifdef MEM_BUS_MASTER_PERF_EN
  logic stall_evt;
  assign stall_evt = (bus.i_req_valid && !i_ready) || (bus.d_req_valid && !d_ready);

  // saturating access and stall counters
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_reads  <= '0;
      perf_writes <= '0;
      perf_stall  <= '0;
    end else begin
      if (accept && !sel_write && perf_reads  != 16'hFFFF) perf_reads  <= perf_reads  + 16'd1;
      if (accept &&  sel_write && perf_writes != 16'hFFFF) perf_writes <= perf_writes + 16'd1;
      if (stall_evt           && perf_stall  != 16'hFFFF) perf_stall  <= perf_stall  + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master: vector table of fetch/load/store
// accesses, a response scoreboard, and hand sequences for reset, mid-access
// reset and contention. Define MEM_BUS_MASTER_PERF_EN to also check counters.
module tb_mem_bus_master;
  import mem_bus_pkg::*;

  localparam int RL = 2;

  typedef struct {
    bit                   is_d;
    bit                   is_write;
    logic [WORD_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] wdata;
    logic [WORD_SIZE-1:0] exp_rdata;
  } vec_t;

  typedef struct {
    bit                   is_d;
    bit                   is_write;
    logic [WORD_SIZE-1:0] rdata;
  } exp_t;

  logic clk;
  logic reset;
  wire  [WORD_SIZE-1:0] data;
  logic [WORD_SIZE-1:0] mem [0:255];

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  vec_t vecs[7];

`ifdef MEM_BUS_MASTER_PERF_EN
  logic [15:0] perf_reads, perf_writes, perf_stall;
`endif

  mem_bus_master_if bus_if ();

  mem_bus_master #(.READ_LATENCY(RL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .data  (data)
`ifdef MEM_BUS_MASTER_PERF_EN
    ,
    .perf_reads  (perf_reads),
    .perf_writes (perf_writes),
    .perf_stall  (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: answers reads combinationally, stores on the clock
  assign data = bus_if.read_m ? mem[bus_if.address[7:0]] : {WORD_SIZE{1'bz}};

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 256; k++) mem[k] <= 16'h0000;
      mem[8'h23] <= 16'h6000;
      mem[8'h10] <= 16'h1234;
      mem[8'h01] <= 16'h1111;
      mem[8'h02] <= 16'h2222;
    end else if (bus_if.write_m) begin
      mem[bus_if.address[7:0]] <= data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit accepted = 0;
    bit got = 0;
    int n = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int addr_err = 0;
    int wdat_err = 0;
    exp_t e;
    @(posedge clk); #1;
    if (v.is_d) begin
      bus_if.d_req_valid = 1'b1;
      bus_if.d_req_write = v.is_write;
      bus_if.d_req_addr  = v.addr;
      bus_if.d_req_wdata = v.wdata;
    end else begin
      bus_if.i_req_valid = 1'b1;
      bus_if.i_req_addr  = v.addr;
    end
    e.is_d = v.is_d; e.is_write = v.is_write; e.rdata = v.exp_rdata;
    sb.push_back(e);
    while (!accepted && n < 20) begin
      @(negedge clk);
      n++;
      if (v.is_d ? bus_if.d_req_ready : bus_if.i_req_ready) accepted = 1;
    end
    chk("accept_in_time", 32'(accepted), 32'd1);
    @(posedge clk); #1;
    bus_if.d_req_valid = 1'b0;
    bus_if.i_req_valid = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus_if.read_m) begin
        rd_cnt++;
        if (bus_if.address !== v.addr) addr_err++;
      end
      if (bus_if.write_m) begin
        wr_cnt++;
        if (bus_if.address !== v.addr) addr_err++;
        if (data !== v.wdata) wdat_err++;
      end
      if (v.is_d ? bus_if.d_resp_valid : bus_if.i_resp_valid) got = 1;
    end
    chk("accept_to_resp", 32'(cyc), v.is_write ? 32'd2 : 32'(RL + 1));
    chk("read_m_cycles", 32'(rd_cnt), v.is_write ? 32'd0 : 32'(RL));
    chk("write_m_cycles", 32'(wr_cnt), v.is_write ? 32'd1 : 32'd0);
    chk("bus_address", 32'(addr_err), 32'd0);
    chk("bus_wdata", 32'(wdat_err), 32'd0);
  endtask

  initial begin
    int n;
    int pulses;
    exp_t e;

    vecs[0] = '{1'b0, 1'b0, 16'h0023, 16'h0000, 16'h6000};
    vecs[1] = '{1'b1, 1'b1, 16'h0050, 16'hBEEF, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 16'h0050, 16'h0000, 16'hBEEF};
    vecs[3] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h1234};
    vecs[4] = '{1'b1, 1'b1, 16'h0011, 16'hA5A5, 16'h0000};
    vecs[5] = '{1'b0, 1'b0, 16'h0011, 16'h0000, 16'hA5A5};
    vecs[6] = '{1'b1, 1'b0, 16'h0023, 16'h0000, 16'h6000};

    reset = 1'b1;
    bus_if.i_req_valid = 1'b0;
    bus_if.i_req_addr  = '0;
    bus_if.d_req_valid = 1'b0;
    bus_if.d_req_write = 1'b0;
    bus_if.d_req_addr  = '0;
    bus_if.d_req_wdata = '0;

    // scoreboard / invariant monitor
    fork
      forever begin
        @(negedge clk);
        chk("strobes_exclusive", 32'(bus_if.read_m && bus_if.write_m), 32'd0);
        if (bus_if.i_resp_valid || bus_if.d_resp_valid) begin
          if (sb.size() == 0) begin
            chk("resp_without_request", {30'd0, bus_if.i_resp_valid, bus_if.d_resp_valid}, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("resp_port", {30'd0, bus_if.d_resp_valid, bus_if.i_resp_valid},
                e.is_d ? 32'd2 : 32'd1);
            if (!e.is_write)
              chk("resp_data", 32'(e.is_d ? bus_if.d_resp_data : bus_if.i_resp_data), 32'(e.rdata));
          end
        end
      end
    join_none

    // reset values held for three cycles
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("reset_ctrl", {26'd0, bus_if.i_req_ready, bus_if.d_req_ready, bus_if.i_resp_valid,
                         bus_if.d_resp_valid, bus_if.read_m, bus_if.write_m}, 32'd0);
      chk("reset_address", 32'(bus_if.address), 32'd0);
      chk("reset_resp_data", {bus_if.i_resp_data, bus_if.d_resp_data}, 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {30'd0, bus_if.i_req_ready, bus_if.d_req_ready}, 32'd3);

    // reset pulsed during RD drops the fetch
    @(posedge clk); #1;
    bus_if.i_req_valid = 1'b1;
    bus_if.i_req_addr  = 16'h0023;
    @(negedge clk);
    chk("drop_accept", 32'(bus_if.i_req_ready), 32'd1);
    @(posedge clk); #1;
    bus_if.i_req_valid = 1'b0;
    @(negedge clk);
    chk("drop_in_rd", 32'(bus_if.read_m), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("drop_read_m_low", 32'(bus_if.read_m), 32'd0);
    chk("drop_resp_data", 32'(bus_if.i_resp_data), 32'd0);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus_if.i_resp_valid || bus_if.d_resp_valid) pulses++;
      @(negedge clk);
    end
    chk("drop_no_resp", 32'(pulses), 32'd0);
    run_vec('{1'b0, 1'b0, 16'h0023, 16'h0000, 16'h6000});

    // table of single accesses
    for (int v = 0; v < 7; v++) run_vec(vecs[v]);

    // fetch and load contend in the same cycle
    @(posedge clk); #1;
    bus_if.i_req_valid = 1'b1;
    bus_if.i_req_addr  = 16'h0001;
    bus_if.d_req_valid = 1'b1;
    bus_if.d_req_write = 1'b0;
    bus_if.d_req_addr  = 16'h0002;
    e.is_d = 1'b1; e.is_write = 1'b0; e.rdata = 16'h2222; sb.push_back(e);
    e.is_d = 1'b0; e.is_write = 1'b0; e.rdata = 16'h1111; sb.push_back(e);
    @(negedge clk);
    chk("contend_grant", {30'd0, bus_if.d_req_ready, bus_if.i_req_ready}, 32'd2);
    @(posedge clk); #1;
    bus_if.d_req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_if.i_req_ready && n < 20);
    chk("contend_i_accept_delay", 32'(n), 32'(RL + 2));
    @(posedge clk); #1;
    bus_if.i_req_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("contend_drain", 32'(sb.size()), 32'd0);

`ifdef MEM_BUS_MASTER_PERF_EN
    @(negedge clk);
    chk("perf_reads", 32'(perf_reads), 32'd8);
    chk("perf_writes", 32'(perf_writes), 32'd2);
    chk("perf_stall_nonzero", 32'(perf_stall != 16'd0), 32'd1);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
